instr_feeder: RTL and testbench
===============================

# instr_feeder

Parametrised, synthesizable instruction feeder for the RISC-V core test harness. It holds the core in reset for a programmable number of cycles, buffers instructions in a FIFO, and issues them to the core over a valid/ready handshake. It supports free-running (burst) and single-step modes, and drives a NOP whenever nothing is being issued. It sits between the stimulus source (bench or loader) and the core's instruction input, replacing per-cycle unconditional instruction driving.

## Interface
Parameters:
- XLEN, 32, instruction width in bits
- DEPTH, 8, FIFO entries; power of two, at least 2
- RST_CYCLES, 1, number of cycles `cpu_rst` is held after reset or flush; at least 1
- NOP, 32'h0000_0013, value driven on `instr` when not valid

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- wr_en  in  1  push `wr_data` into the FIFO
- wr_data  in  XLEN  instruction to enqueue
- full  out  1  FIFO holds DEPTH entries
- empty  out  1  FIFO holds 0 entries
- level  out  $clog2(DEPTH)+1  current occupancy
- overflow  out  1  sticky; set when a write arrives while full
- step_mode  in  1  0 = burst, 1 = single-step
- step  in  1  single-cycle pulse granting one issue credit
- flush  in  1  empties the FIFO and restarts the core reset sequence
- cpu_rst  out  1  reset to the core, active-high
- instr_valid  out  1  `instr` is a real instruction
- instr  out  XLEN  FIFO head when valid, NOP otherwise
- instr_ready  in  1  core accepts `instr` this cycle
- issued  out  16  count of completed handshakes; wraps modulo 2^16

## Operation
- FSM with two states:
  - RESET: `cpu_rst` = 1; a down-counter loads RST_CYCLES.
  - RUN: `cpu_rst` = 0.
- RESET → RUN after RST_CYCLES rising edges.
- RUN → RESET on `flush`.
- Asynchronous `rst` forces RESET, an empty FIFO, and all counters to their reset values.
- Issue rule: `instr_valid` = (state==RUN) && !empty && (!step_mode || credit).
- `instr` = head entry when `instr_valid`, else NOP.
- Transfer happens when `instr_valid && instr_ready`. On a transfer: pop the head, increment `issued`, clear `credit`.
- While valid and not ready, `instr` and `instr_valid` hold stable.
- Credit is a single-bit register:
  - `step` sets it.
  - Extra `step` pulses while credit is pending are discarded (no accumulation).
  - `step` in burst mode is ignored.
  - Credit is cleared on flush and on any switch of `step_mode`.
- Writes:
  - Accepted when !full, including during RESET.
  - When full, the write is dropped and `overflow` is set, even if a pop occurs in the same cycle.
  - `overflow` clears only on `rst`.
- Simultaneous push and pop when not full: both take effect and `level` is unchanged.
- Flush:
  - Empties the FIFO (`level` = 0), clears credit, enters RESET.
  - Any write in the flush cycle is discarded.
  - `issued` is not cleared.
- Pointers are $clog2(DEPTH) bits and wrap naturally.
- `level` = count of entries, from 0 to DEPTH.

## Timing
- Reset values:
  - `cpu_rst` = 1, `instr_valid` = 0, `instr` = NOP
  - `full` = 0, `empty` = 1, `level` = 0
  - `overflow` = 0, `issued` = 0
- After `rst` deasserts, `cpu_rst` falls after exactly RST_CYCLES rising edges.
- Latency:
  - A write at edge N is visible on `instr`/`instr_valid` after edge N (one cycle) if in RUN and eligible.
  - A `step` at edge N makes `instr_valid` high after edge N.
- All outputs are derived from registers only; there is no combinational path from `instr_ready`, `wr_en` or `step` to any output.
- Back-to-back issue: one instruction per cycle in burst mode with `instr_ready` held high.
- `flush` in RUN: after the edge, `cpu_rst` = 1 and `instr_valid` = 0.
- `rst` asserted mid-handshake: outputs go to reset values immediately (asynchronously); the pending instruction is lost.

## Test plan
- Reset sequence, RST_CYCLES=3: deassert `rst` → `cpu_rst` high for exactly 3 edges, `instr` = 0x00000013, `issued` = 0.
- Burst mode, write 0x00500093, 0x00A00113, 0x002081B3 with ready=1 → three consecutive valid cycles in order, `issued` = 3, then NOP with `empty` = 1.
- Backpressure: ready=0 for 4 cycles with one queued entry → `instr` stable and valid, `issued` unchanged; ready=1 → transfer on the next edge.
- Single-step: queue 2 entries, `step_mode` = 1, pulse `step` twice in consecutive cycles → exactly one issue; a third `step` → second issue.
- Full/overflow, DEPTH=8: 9 writes with ready=0 → `full` = 1, `level` = 8, `overflow` = 1, the 9th value is never issued.
- Flush mid-stream with 5 entries queued → `level` = 0, `cpu_rst` high for RST_CYCLES, `issued` retained; a subsequent write issues normally.

Source files
------------

// File: rtl/instr_feeder_if.sv
// Bundles the instruction feeder's stimulus, status and core-side handshake signals.
// slave = the feeder; master = the stimulus source plus core.
`timescale 1ns/1ps
interface instr_feeder_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic            wr_en;
  logic [XLEN-1:0] wr_data;
  logic            full;
  logic            empty;
  logic [LW-1:0]   level;
  logic            overflow;
  logic            step_mode;
  logic            step;
  logic            flush;
  logic            cpu_rst;
  logic            instr_valid;
  logic [XLEN-1:0] instr;
  logic            instr_ready;
  logic [15:0]     issued;

  modport master (
    output wr_en, wr_data, step_mode, step, flush, instr_ready,
    input  full, empty, level, overflow, cpu_rst, instr_valid, instr, issued
  );

  modport slave (
    input  wr_en, wr_data, step_mode, step, flush, instr_ready,
    output full, empty, level, overflow, cpu_rst, instr_valid, instr, issued
  );
endinterface

// File: rtl/instr_feeder.sv
// Holds the core in reset, buffers instructions in a FIFO and issues them over
// valid/ready in burst or single-step mode, driving NOP when idle.
`timescale 1ns/1ps
module instr_feeder #(
  parameter int unsigned     XLEN       = 32,
  parameter int unsigned     DEPTH      = 8,
  parameter int unsigned     RST_CYCLES = 1,
  parameter logic [XLEN-1:0] NOP        = XLEN'(32'h0000_0013)
) (
  input logic           clk,
  input logic           rst,
  instr_feeder_if.slave bus
);
  localparam int unsigned   AW       = $clog2(DEPTH);
  localparam int unsigned   LW       = AW + 1;
  localparam int unsigned   CW       = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(RST_CYCLES - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  typedef enum logic {
    S_RESET = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [XLEN-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [LW-1:0]   count, count_nxt;
  logic            full_q, empty_q, overflow_q;
  logic            credit, credit_nxt, mode_q;
  logic            valid_q, valid_nxt;
  logic [XLEN-1:0] instr_q, head_nxt;
  logic [15:0]     issued_q;
  logic            push, pop;

  // Next-state for FSM, FIFO and credit; valid/instr are computed from the
  // post-edge state so they can be registered without adding a cycle.
  always_comb begin
    pop        = valid_q && bus.instr_ready;
    push       = bus.wr_en && !full_q && !bus.flush;
    wr_ptr_nxt = wr_ptr + AW'(push);
    rd_ptr_nxt = rd_ptr + AW'(pop);
    count_nxt  = count + LW'(push) - LW'(pop);
    state_nxt  = state;
    cnt_nxt    = cnt;

    credit_nxt = credit;
    if (pop)
      credit_nxt = 1'b0;
    else if (bus.step && bus.step_mode)
      credit_nxt = 1'b1;
    if (bus.step_mode != mode_q)
      credit_nxt = 1'b0;

    if (state == S_RESET) begin
      if (cnt == '0)
        state_nxt = S_RUN;
      else
        cnt_nxt = cnt - 1'b1;
    end

    if (bus.flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      count_nxt  = '0;
      credit_nxt = 1'b0;
      state_nxt  = S_RESET;
      cnt_nxt    = CNT_LOAD;
    end

    valid_nxt = (state_nxt == S_RUN) && (count_nxt != '0) &&
                (!bus.step_mode || credit_nxt);
    // Bypass: the slot becoming head may be written at this same edge.
    head_nxt  = (push && (wr_ptr == rd_ptr_nxt)) ? bus.wr_data : mem[rd_ptr_nxt];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_RESET;
      cnt        <= CNT_LOAD;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      credit     <= 1'b0;
      mode_q     <= 1'b0;
      valid_q    <= 1'b0;
      instr_q    <= NOP;
      issued_q   <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      wr_ptr  <= wr_ptr_nxt;
      rd_ptr  <= rd_ptr_nxt;
      count   <= count_nxt;
      full_q  <= (count_nxt == LVL_FULL);
      empty_q <= (count_nxt == '0);
      credit  <= credit_nxt;
      mode_q  <= bus.step_mode;
      valid_q <= valid_nxt;
      instr_q <= valid_nxt ? head_nxt : NOP;
      if (bus.wr_en && full_q)
        overflow_q <= 1'b1;
      if (pop)
        issued_q <= issued_q + 16'd1;
    end
  end

  // Storage array carries no reset; only slots below level are ever read out.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= bus.wr_data;
  end

  assign bus.full        = full_q;
  assign bus.empty       = empty_q;
  assign bus.level       = count;
  assign bus.overflow    = overflow_q;
  assign bus.cpu_rst     = (state == S_RESET);
  assign bus.instr_valid = valid_q;
  assign bus.instr       = instr_q;
  assign bus.issued      = issued_q;

endmodule

// File: tb/tb_instr_feeder.sv
// Self-checking bench for instr_feeder: per-cycle vector table plus scoreboard
// of issued instructions, with hand-written overflow, flush and async-reset cases.
`timescale 1ns/1ps
module tb_instr_feeder;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned RSTC  = 3;
  localparam logic [31:0] NOPV  = 32'h0000_0013;
  localparam int          NVEC  = 20;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  instr_feeder_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  instr_feeder #(
    .XLEN(XLEN), .DEPTH(DEPTH), .RST_CYCLES(RSTC), .NOP(NOPV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic        wr;
    logic [31:0] data;
    logic        mode;
    logic        stp;
    logic        rdy;
    logic        e_valid;
    int          e_level;
    logic        e_cpu_rst;
    int          e_issued;
  } vec_t;

  vec_t        vecs [NVEC];
  logic [31:0] sb [$];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus; the scoreboard learns every accepted write.
  task automatic drive(input logic wr, input logic [31:0] d, input logic mode,
                       input logic stp, input logic fl, input logic rdy);
    bus.wr_en       = wr;
    bus.wr_data     = d;
    bus.step_mode   = mode;
    bus.step        = stp;
    bus.flush       = fl;
    bus.instr_ready = rdy;
    if (fl)
      sb.delete();
    else if (wr && sb.size() < DEPTH)
      sb.push_back(d);
  endtask

  // Compare any transfer happening at this edge, advance, then release pulses.
  task automatic tick();
    if (bus.instr_valid && bus.instr_ready) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL xfer_unexpected: got %h expected no transfer", bus.instr);
      end else begin
        check("xfer_instr", bus.instr, sb.pop_front());
      end
    end
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    bus.step  = 1'b0;
    bus.flush = 1'b0;
  endtask

  task automatic expect_state(input string tag, input logic v, input int lvl,
                              input logic cr, input int iss);
    check({tag, ".valid"},   32'(bus.instr_valid), 32'(v));
    check({tag, ".level"},   32'(bus.level),       32'(lvl));
    check({tag, ".cpu_rst"}, 32'(bus.cpu_rst),     32'(cr));
    check({tag, ".issued"},  32'(bus.issued),      32'(iss));
    check({tag, ".empty"},   32'(bus.empty),       32'(lvl == 0));
    check({tag, ".full"},    32'(bus.full),        32'(lvl == DEPTH));
    if (!v)
      check({tag, ".nop"}, bus.instr, NOPV);
    else if (sb.size() > 0)
      check({tag, ".head"}, bus.instr, sb[0]);
  endtask

  initial begin
    //          wr    data          mode  stp   rdy   valid lvl cpu_rst iss
    vecs[0]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 0};
    vecs[1]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 0};
    vecs[2]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0};
    vecs[3]  = '{1'b1, 32'h00500093, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b0, 0};
    vecs[4]  = '{1'b1, 32'h00A00113, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b0, 1};
    vecs[5]  = '{1'b1, 32'h002081B3, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b0, 2};
    vecs[6]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 3};
    vecs[7]  = '{1'b1, 32'h11111111, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0, 3};
    vecs[8]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0, 3};
    vecs[9]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0, 3};
    vecs[10] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0, 3};
    vecs[11] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 4};
    vecs[12] = '{1'b1, 32'h22222222, 1'b1, 1'b0, 1'b1, 1'b0, 1, 1'b0, 4};
    vecs[13] = '{1'b1, 32'h33333333, 1'b1, 1'b0, 1'b1, 1'b0, 2, 1'b0, 4};
    vecs[14] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b1, 2, 1'b0, 4};
    vecs[15] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 1, 1'b0, 5};
    vecs[16] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 1, 1'b0, 5};
    vecs[17] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b1, 1, 1'b0, 5};
    vecs[18] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0, 6};
    vecs[19] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 6};

    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst.cpu_rst",  32'(bus.cpu_rst),     32'd1);
    check("rst.valid",    32'(bus.instr_valid), 32'd0);
    check("rst.instr",    bus.instr,            NOPV);
    check("rst.full",     32'(bus.full),        32'd0);
    check("rst.empty",    32'(bus.empty),       32'd1);
    check("rst.level",    32'(bus.level),       32'd0);
    check("rst.overflow", 32'(bus.overflow),    32'd0);
    check("rst.issued",   32'(bus.issued),      32'd0);
    rst = 1'b0;

    // Reset release, burst, backpressure and single-step from the table.
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].wr, vecs[i].data, vecs[i].mode, vecs[i].stp, 1'b0, vecs[i].rdy);
      tick();
      expect_state($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_level,
                   vecs[i].e_cpu_rst, vecs[i].e_issued);
    end

    // Nine writes into an eight-entry FIFO with the core stalled.
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 32'h0000_1000 + 32'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    expect_state("ovf.fill", 1'b1, 8, 1'b0, 6);
    check("ovf.overflow", 32'(bus.overflow), 32'd1);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
    end
    expect_state("ovf.drain", 1'b0, 0, 1'b0, 14);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    expect_state("ovf.ninth", 1'b0, 0, 1'b0, 14);
    check("ovf.sticky", 32'(bus.overflow), 32'd1);

    // Flush with five queued entries and a write in the flush cycle.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h0000_2000 + 32'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    expect_state("fl.queued", 1'b1, 5, 1'b0, 14);
    drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    expect_state("fl.edge", 1'b0, 0, 1'b1, 14);
    for (int i = 0; i < int'(RSTC) - 1; i++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      expect_state($sformatf("fl.hold%0d", i), 1'b0, 0, 1'b1, 14);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    expect_state("fl.release", 1'b0, 0, 1'b0, 14);
    drive(1'b1, 32'h4444_4444, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    expect_state("fl.write", 1'b1, 1, 1'b0, 14);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    expect_state("fl.issue", 1'b0, 0, 1'b0, 15);

    // Asynchronous reset while an instruction waits on a stalled core.
    drive(1'b1, 32'h5555_5555, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    expect_state("ar.pending", 1'b1, 1, 1'b0, 15);
    #2 rst = 1'b1;
    #1;
    sb.delete();
    expect_state("ar.async", 1'b0, 0, 1'b1, 0);
    check("ar.overflow", 32'(bus.overflow), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
